uart_tx_sched: RTL
==================

# uart_tx_sched

Round-robin transmit scheduler that shares one UART transmitter core between `N_REQ` byte-producing requesters. It arbitrates between pending requests and latches the winning byte. It then drives the core's one-cycle `tx_req`/`tx_data` strobe and tracks the core's `tx_busy` through start and completion. Optional packet locking keeps multi-byte messages from one requester contiguous on the serial line.

## Interface
Parameters:
- `N_REQ`, 4: number of requesters, 2..8.
- `START_TO`, 15: maximum clk cycles to wait for `uart_tx_busy` to rise after a strobe.

Ports. One clock; reset is asynchronous and active-low.
- `clk`  in  1  system clock, shared with the UART core.
- `rst_n`  in  1  async active-low reset.
- `en`  in  1  enable new arbitration; an in-flight byte always completes.
- `req_valid`  in  N_REQ  requester i has a byte pending; held until `req_ready[i]`.
- `req_data`  in  8*N_REQ  byte of requester i in bits [8i+7:8i].
- `req_last`  in  N_REQ  byte closes requester i's packet (releases the lock).
- `req_ready`  out  N_REQ  one-cycle pulse: byte of requester i accepted.
- `uart_tx_data`  out  8  byte to the core.
- `uart_tx_req`  out  1  one-cycle transmit strobe to the core.
- `uart_tx_busy`  in  1  core busy flag.
- `grant_id`  out  3  index of the current or last granted requester.
- `sched_busy`  out  1  high in every state except ARB.
- `locked`  out  1  a packet lock is held by `grant_id`.
- `timeout_err`  out  1  one-cycle pulse: the core failed to start.

## Operation
States: ARB, ISSUE, WAIT_START, WAIT_END. Reset state is ARB.

**ARB**
- Eligibility:
  - `locked` = 1: only `grant_id` is eligible.
  - `locked` = 0: all requesters are eligible.
- Pick rule: among eligible requesters with `req_valid` set, pick the first index searching upward from `ptr+1`, wrapping modulo N_REQ.
- Guards: no pick when `en` = 0 or `uart_tx_busy` = 1.
- On a pick g:
  - Latch `req_data[g]` into `uart_tx_data` and `req_last[g]` into `last_q`.
  - Set `grant_id` to g and `ptr` to g.
  - Register `req_ready[g]` = 1.
  - Go to ISSUE.

**ISSUE**
- `uart_tx_req` = 1 for exactly this cycle; `uart_tx_data` is stable.
- `req_ready[g]` is high this cycle.
- `locked` is updated to `!last_q`.
- Go to WAIT_START and clear the timeout counter.

**WAIT_START**
- `uart_tx_busy` = 1: go to WAIT_END.
- Counter reaches START_TO:
  - Pulse `timeout_err`.
  - Clear `locked`; the byte is dropped.
  - Go to ARB.

**WAIT_END**
- Go to ARB when `uart_tx_busy` = 0.

**Lock behaviour**
- While locked, a deasserted `req_valid[grant_id]` stalls the scheduler in ARB, and other requesters wait.
- `en` = 0 does not clear `locked`.

## Timing
- Reset values:
  - Outputs: `req_ready` = 0, `uart_tx_req` = 0, `uart_tx_data` = 0, `grant_id` = 0, `sched_busy` = 0, `locked` = 0, `timeout_err` = 0.
  - Internal: `ptr` = N_REQ-1, so requester 0 has first priority.
- Latency: ARB sample edge → `uart_tx_req` and `req_ready` high in the next cycle (1 cycle). All outputs are registered.
- Handshake:
  - Requester i may change `req_valid`, `req_data` and `req_last` only on the edge that ends its `req_ready` cycle, or while its `req_valid` is low.
  - The minimum gap between two accepts is 4 cycles: ARB, ISSUE, WAIT_START, WAIT_END.
- Simultaneous events:
  - Several valid requests in one cycle: rotation order decides.
  - A requester re-asserting in the same ARB cycle as others: rotation order decides.
- Wrap-around: `ptr` = N_REQ-1 searches starting from index 0.
- Busy at entry: if `uart_tx_busy` is already high in ARB (core owned elsewhere or still finishing), the scheduler waits.
- Reset mid-operation: all state returns to its reset value immediately. A byte already handed to the core is not tracked.
- Width rule: the timeout counter is wide enough for START_TO, defined as `$clog2(START_TO+1)` bits, and is compared for equality.

## Structure
- Package `uart_ctrl_pkg` contains:
  - The state enum `sched_state_t` (ARB, ISSUE, WAIT_START, WAIT_END).
  - The constant `UART_DATA_W` = 8.
  - The default `START_TO`.
- Sub-module `rr_pick`, combinational: inputs request vector, mask and `ptr`; outputs `found` and index. It is reusable by other schedulers in the design.
- Top-level contains the FSM, data latch, lock flag and timeout counter.

## Test plan
- **Single byte:** reset, then `req_valid[2]` with data 0xA5, last = 1, and a core model that raises busy 1 cycle after the strobe and holds it 160 cycles.
  - → `req_ready[2]` and `uart_tx_req` are high in the same cycle, with `uart_tx_data` = 0xA5.
  - → `sched_busy` falls 1 cycle after busy falls.
- **Round-robin:** all 4 requesters continuously valid with last = 1.
  - → Grant order is 0, 1, 2, 3, 0, and each `req_ready` pulse is exactly 1 cycle.
- **Lock:** requester 1 sends 0x10 (last = 0), 0x11 (last = 0), 0x12 (last = 1) while requester 0 is valid throughout.
  - → Requester 1's three bytes go out back to back, then requester 0; `locked` is low after 0x12.
- **Timeout:** the core never raises busy.
  - → `timeout_err` pulses once START_TO cycles after the strobe, `locked` is cleared, and the next requester is granted.
- **Enable gating:** `en` drops during WAIT_END.
  - → The current byte completes; no new `uart_tx_req` is issued until `en` returns high.
- **Reset mid-operation:** `rst_n` is asserted during WAIT_END.
  - → All outputs are 0 at once, and the first grant after release goes to requester 0.

Source files
------------

// File: rtl/uart_ctrl_pkg.sv
// Shared types and constants for the UART transmit scheduling logic.
package uart_ctrl_pkg;

  localparam int UART_DATA_W      = 8;
  localparam int START_TO_DEFAULT = 15;
  localparam int ID_W             = 3;

  typedef enum logic [1:0] {
    ARB        = 2'd0,
    ISSUE      = 2'd1,
    WAIT_START = 2'd2,
    WAIT_END   = 2'd3
  } sched_state_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first masked request searching upward from ptr+1.
module rr_pick #(
  parameter int N     = 4,
  parameter int IDX_W = 3
) (
  input  logic [N-1:0]     req,
  input  logic [N-1:0]     mask,
  input  logic [IDX_W-1:0] ptr,
  output logic             found,
  output logic [IDX_W-1:0] idx
);

  logic [N-1:0] cand;
  assign cand = req & mask;

  // Walk offsets from farthest to nearest so the nearest candidate wins.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    for (int k = N; k >= 1; k--) begin
      int j;
      j = (int'(ptr) + k) % N;
      if (cand[j]) begin
        found = 1'b1;
        idx   = IDX_W'(j);
      end
    end
  end

endmodule

// File: rtl/uart_tx_sched.sv
// Round-robin scheduler sharing one UART transmitter between N_REQ requesters,
// with optional packet locking and a start timeout.
module uart_tx_sched
  import uart_ctrl_pkg::*;
#(
  parameter int N_REQ    = 4,
  parameter int START_TO = START_TO_DEFAULT
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         en,
  input  logic [N_REQ-1:0]             req_valid,
  input  logic [UART_DATA_W*N_REQ-1:0] req_data,
  input  logic [N_REQ-1:0]             req_last,
  output logic [N_REQ-1:0]             req_ready,
  output logic [UART_DATA_W-1:0]       uart_tx_data,
  output logic                         uart_tx_req,
  input  logic                         uart_tx_busy,
  output logic [ID_W-1:0]              grant_id,
  output logic                         sched_busy,
  output logic                         locked,
  output logic                         timeout_err
);

  localparam int CNT_W  = $clog2(START_TO + 1);
  localparam int SLOT_N = 2 ** ID_W;

  sched_state_t            state;
  logic [ID_W-1:0]         ptr;
  logic                    last_q;
  logic [CNT_W-1:0]        cnt;
  logic [CNT_W-1:0]        cnt_inc;

  logic [N_REQ-1:0]        elig_mask;
  logic [N_REQ-1:0]        pick_onehot;
  logic                    pick_found;
  logic [ID_W-1:0]         pick_idx;
  logic [UART_DATA_W-1:0]  data_arr [SLOT_N];
  logic                    last_arr [SLOT_N];

  assign cnt_inc = cnt + 1'b1;

  genvar gi;
  generate
    for (gi = 0; gi < N_REQ; gi++) begin : g_req
      assign elig_mask[gi]   = !locked || (grant_id == ID_W'(gi));
      assign pick_onehot[gi] = (pick_idx == ID_W'(gi));
    end
    // Pad the unpacked views to a full ID_W-indexed table so grant ids index them directly.
    for (gi = 0; gi < SLOT_N; gi++) begin : g_slot
      if (gi < N_REQ) begin : g_used
        assign data_arr[gi] = req_data[gi*UART_DATA_W +: UART_DATA_W];
        assign last_arr[gi] = req_last[gi];
      end else begin : g_pad
        assign data_arr[gi] = '0;
        assign last_arr[gi] = 1'b0;
      end
    end
  endgenerate

  rr_pick #(
    .N     (N_REQ),
    .IDX_W (ID_W)
  ) u_pick (
    .req   (req_valid),
    .mask  (elig_mask),
    .ptr   (ptr),
    .found (pick_found),
    .idx   (pick_idx)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ARB;
      ptr          <= ID_W'(N_REQ - 1);
      last_q       <= 1'b0;
      cnt          <= '0;
      req_ready    <= '0;
      uart_tx_req  <= 1'b0;
      uart_tx_data <= '0;
      grant_id     <= '0;
      sched_busy   <= 1'b0;
      locked       <= 1'b0;
      timeout_err  <= 1'b0;
    end else begin
      req_ready   <= '0;
      uart_tx_req <= 1'b0;
      timeout_err <= 1'b0;
      case (state)
        ARB: begin
          if (en && !uart_tx_busy && pick_found) begin
            uart_tx_data <= data_arr[pick_idx];
            last_q       <= last_arr[pick_idx];
            grant_id     <= pick_idx;
            ptr          <= pick_idx;
            req_ready    <= pick_onehot;
            uart_tx_req  <= 1'b1;
            sched_busy   <= 1'b1;
            state        <= ISSUE;
          end
        end
        ISSUE: begin
          locked <= !last_q;
          cnt    <= '0;
          state  <= WAIT_START;
        end
        WAIT_START: begin
          // Timeout fires after START_TO whole cycles without busy; the byte is dropped.
          if (uart_tx_busy) begin
            state <= WAIT_END;
          end else if (cnt_inc == CNT_W'(START_TO)) begin
            timeout_err <= 1'b1;
            locked      <= 1'b0;
            sched_busy  <= 1'b0;
            state       <= ARB;
          end else begin
            cnt <= cnt_inc;
          end
        end
        WAIT_END: begin
          if (!uart_tx_busy) begin
            sched_busy <= 1'b0;
            state      <= ARB;
          end
        end
        default: state <= ARB;
      endcase
    end
  end

endmodule
